if_fetch: RTL and testbench

Instruction-fetch stage of the Toru CPU pipeline, directly upstream of the decode stage. It owns the program counter and runs a req/ack handshake with instruction memory. It absorbs downstream stalls with a one-entry hold buffer, applies branch redirects with MIPS delay-slot semantics, and applies flush redirects. Its registered outputs (`pc_o`, `inst_o`, `valid_o`) are the IF/ID boundary that decode consumes.

---
 rtl/if_fetch.sv | 170 +++++++++++++++++
 tb/tb_if_fetch.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the PC and the imem req/ack handshake,
//   and drives the registered IF/ID boundary (pc_o, inst_o, valid_o).
// Latency: valid_o rises on the ack edge; 1 instr/cycle with zero-wait memory.
// Backpressure: stall_i freezes IF/ID. An ack taken under stall parks the word
//   in a one-entry hold buffer, and the request drops until the stall releases.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   stall_i / flush_i, flush_pc_i    decode stall; flush restart request
//   branch_flag_i, branch_target_i   taken branch from decode (delay slot kept)
//   imem_req_o, imem_addr_o          fetch request, held stable until ack
//   imem_ack_i, imem_data_i          memory completion and instruction word
//   pc_o, inst_o, valid_o            IF/ID outputs; inst_o is 0 when not valid
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  logic        done;
  logic        branch_acc;
  logic [31:0] next_pc;

  assign imem_req_o  = ((state_q == FETCH) || (state_q == DRAIN)) && !rst;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_out_q;
  assign inst_o      = inst_q;
  assign valid_o     = valid_q;

  assign done       = imem_req_o && imem_ack_i;
  // A stalled branch is ignored; decode keeps presenting it until accepted.
  assign branch_acc = branch_flag_i && !stall_i;
  // Successor of the PC being handed off. A pending redirect outranks a
  // branch arriving now, because the redirect belongs to an older branch.
  assign next_pc    = redir_valid_q ? redir_pc_q :
                      (branch_acc ? branch_target_i : pc_q + 32'd4);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    buf_inst_d    = buf_inst_q;
    pc_out_d      = pc_out_q;
    inst_d        = inst_q;
    valid_d       = valid_q;

    if (flush_i) begin
      valid_d       = 1'b0;
      inst_d        = 32'd0;
      redir_valid_d = 1'b0;
      buf_inst_d    = 32'd0;
      case (state_q)
        FETCH: begin
          if (done) begin
            pc_d    = flush_pc_i;
            state_d = FETCH;
          end else begin
            // The request cannot be withdrawn; absorb its ack in DRAIN first.
            state_d    = DRAIN;
            redir_pc_d = flush_pc_i;
          end
        end
        DRAIN: begin
          redir_pc_d = flush_pc_i;
          if (done) begin
            pc_d    = flush_pc_i;
            state_d = FETCH;
          end
        end
        default: begin
          pc_d    = flush_pc_i;
          state_d = FETCH;
        end
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (done && !stall_i) begin
            pc_out_d      = pc_q;
            inst_d        = imem_data_i;
            valid_d       = 1'b1;
            pc_d          = next_pc;
            redir_valid_d = 1'b0;
          end else if (done) begin
            buf_inst_d = imem_data_i;
            state_d    = HOLD;
          end else if (!stall_i) begin
            valid_d = 1'b0;
            inst_d  = 32'd0;
            // The delay slot is still outstanding; remember where to go next.
            if (branch_acc) begin
              redir_valid_d = 1'b1;
              redir_pc_d    = branch_target_i;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            pc_out_d      = pc_q;
            inst_d        = buf_inst_q;
            valid_d       = 1'b1;
            pc_d          = next_pc;
            redir_valid_d = 1'b0;
            state_d       = FETCH;
          end
        end
        DRAIN: begin
          valid_d = 1'b0;
          inst_d  = 32'd0;
          if (done) begin
            pc_d    = redir_pc_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
      buf_inst_q    <= 32'd0;
      pc_out_q      <= 32'd0;
      inst_q        <= 32'd0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      buf_inst_q    <= buf_inst_d;
      pc_out_q      <= pc_out_d;
      inst_q        <= inst_d;
      valid_q       <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scenario tasks for if_fetch against a wait-state memory model.
// Latency: memory acks wait_n cycles after a request first appears.
// Backpressure: stall_i and flush_i are driven per scenario from the tasks.
module tb_if_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = 32'd0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  int passed = 0;
  int total  = 0;
  int wait_n = 0;
  int wcnt   = 0;
  logic        edge_req = 1'b0;
  logic        edge_ack = 1'b0;
  logic        edge_stall = 1'b0;
  logic [31:0] edge_addr = 32'd0;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .flush_pc_i(flush_pc_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_data_i(imem_data_i), .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A00_0003;
  endfunction

  assign imem_data_i = mem_f(imem_addr_o);

  always @(negedge clk) begin
    #2;
    imem_ack_i = imem_req_o && (wcnt >= wait_n);
  end

  always @(posedge clk) begin
    if (!imem_req_o || imem_ack_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Called at a falling edge; samples the pre-edge view, returns at next falling edge.
  task automatic tick();
    #3;
    edge_req   = imem_req_o;
    edge_ack   = imem_ack_i;
    edge_addr  = imem_addr_o;
    edge_stall = stall_i;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc = a;
    e.inst = mem_f(a);
    exp_q.push_back(e);
  endtask

  task automatic redirect(input logic [31:0] a);
    flush_pc_i = a;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (imem_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req_o); else passed++;
    total++; if (imem_addr_o !== RST_PC) $display("FAIL reset_addr: got %h want %h", imem_addr_o, RST_PC); else passed++;
    total++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else passed++;
    total++; if (inst_o !== 32'd0) $display("FAIL reset_inst: got %h want 0", inst_o); else passed++;
    total++; if (pc_o !== 32'd0) $display("FAIL reset_pc: got %h want 0", pc_o); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    exp_t e;
    int c;
    int last;
    wait_n = 0;
    exp_q.delete();
    for (int k = 0; k < 5; k++) push(RST_PC + 32'(4 * k));
    c = 0;
    last = -1;
    while (exp_q.size() > 0 && c < 40) begin
      tick();
      if (c == 0) begin
        total++; if (edge_req !== 1'b1 || edge_addr !== RST_PC) $display("FAIL first_req: got req=%b addr=%h want 1 %h", edge_req, edge_addr, RST_PC); else passed++;
      end
      if (valid_o && !edge_stall) begin
        e = exp_q.pop_front();
        total++; if (pc_o !== e.pc || inst_o !== e.inst) $display("FAIL stream: got pc=%h inst=%h want pc=%h inst=%h", pc_o, inst_o, e.pc, e.inst); else passed++;
        total++; if (imem_addr_o !== pc_o + 32'd4) $display("FAIL stream_addr_ahead: got %h want %h", imem_addr_o, pc_o + 32'd4); else passed++;
        if (last >= 0) begin
          total++; if (c != last + 1) $display("FAIL stream_rate: got cycle %0d want %0d", c, last + 1); else passed++;
        end
        last = c;
      end
      c++;
    end
    total++; if (exp_q.size() != 0) $display("FAIL stream_timeout: got %0d pending want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_wait();
    exp_t e;
    int c;
    int gap;
    bit seen;
    wait_n = 2;
    redirect(32'h0000_0500);
    exp_q.delete();
    for (int k = 0; k < 4; k++) push(32'h0000_0500 + 32'(4 * k));
    c = 0; gap = 0; seen = 1'b0;
    while (exp_q.size() > 0 && c < 60) begin
      tick();
      if (edge_req && !edge_ack && imem_req_o) begin
        total++; if (imem_addr_o !== edge_addr) $display("FAIL wait_addr_stable: got %h want %h", imem_addr_o, edge_addr); else passed++;
      end
      if (valid_o && !edge_stall) begin
        e = exp_q.pop_front();
        total++; if (pc_o !== e.pc || inst_o !== e.inst) $display("FAIL wait_seq: got pc=%h inst=%h want pc=%h inst=%h", pc_o, inst_o, e.pc, e.inst); else passed++;
        if (seen) begin
          total++; if (gap != 2) $display("FAIL wait_bubbles: got %0d want 2", gap); else passed++;
        end
        seen = 1'b1;
        gap = 0;
      end else begin
        total++; if (inst_o !== 32'd0) $display("FAIL bubble_inst: got %h want 0", inst_o); else passed++;
        gap++;
      end
      c++;
    end
    total++; if (exp_q.size() != 0) $display("FAIL wait_timeout: got %0d pending want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_stall();
    exp_t e;
    int c;
    logic [31:0] frz_pc;
    logic [31:0] frz_inst;
    wait_n = 0;
    redirect(32'h0000_0600);
    exp_q.delete();
    for (int k = 0; k < 6; k++) push(32'h0000_0600 + 32'(4 * k));
    c = 0; frz_pc = 32'd0; frz_inst = 32'd0;
    while (exp_q.size() > 0 && c < 40) begin
      stall_i = (c >= 3 && c < 6);
      if (c == 3) begin
        frz_pc = pc_o;
        frz_inst = inst_o;
      end
      if (c == 4 || c == 5) begin
        total++; if (imem_req_o !== 1'b0) $display("FAIL hold_req: got %b want 0", imem_req_o); else passed++;
      end
      tick();
      if (edge_stall) begin
        total++; if (pc_o !== frz_pc || inst_o !== frz_inst || valid_o !== 1'b1) $display("FAIL stall_frozen: got pc=%h inst=%h v=%b want pc=%h inst=%h v=1", pc_o, inst_o, valid_o, frz_pc, frz_inst); else passed++;
      end
      if (valid_o && !edge_stall) begin
        e = exp_q.pop_front();
        total++; if (pc_o !== e.pc || inst_o !== e.inst) $display("FAIL stall_seq: got pc=%h inst=%h want pc=%h inst=%h", pc_o, inst_o, e.pc, e.inst); else passed++;
      end
      c++;
    end
    stall_i = 1'b0;
    total++; if (exp_q.size() != 0) $display("FAIL stall_timeout: got %0d pending want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_branch(input int wn);
    exp_t e;
    int c;
    bit done_br;
    bit br_now;
    logic [31:0] want_addr;
    wait_n = wn;
    redirect(32'h0000_01F8);
    exp_q.delete();
    push(32'h0000_01F8); push(32'h0000_01FC); push(32'h0000_0200);
    push(32'h0000_0204); push(32'h0000_0400); push(32'h0000_0404);
    want_addr = (wn == 0) ? 32'h0000_0400 : 32'h0000_0204;
    c = 0; done_br = 1'b0;
    while (exp_q.size() > 0 && c < 80) begin
      branch_target_i = 32'h0000_0400;
      branch_flag_i = !done_br && (valid_o === 1'b1) && (pc_o === 32'h0000_0200);
      br_now = branch_flag_i;
      tick();
      branch_flag_i = 1'b0;
      if (br_now) begin
        done_br = 1'b1;
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== want_addr) $display("FAIL branch_next_req: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, want_addr); else passed++;
      end
      if (valid_o && !edge_stall) begin
        e = exp_q.pop_front();
        total++; if (pc_o !== e.pc || inst_o !== e.inst) $display("FAIL branch_seq_w%0d: got pc=%h inst=%h want pc=%h inst=%h", wn, pc_o, inst_o, e.pc, e.inst); else passed++;
      end
      c++;
    end
    total++; if (exp_q.size() != 0) $display("FAIL branch_timeout: got %0d pending want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_flush_inflight();
    exp_t e;
    int c;
    bit found;
    bit acked;
    wait_n = 4;
    redirect(32'h0000_0300);
    exp_q.delete();
    c = 0; found = 1'b0; acked = 1'b0;
    while (!found && c < 40) begin
      if (imem_req_o === 1'b1 && imem_addr_o === 32'h0000_0300) found = 1'b1;
      else begin tick(); c++; end
    end
    total++; if (!found) $display("FAIL flush_reach_300: got no request want addr 00000300"); else passed++;
    if (found) begin
      flush_pc_i = 32'h0000_0080;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0300) $display("FAIL drain_addr: got req=%b addr=%h want 1 00000300", imem_req_o, imem_addr_o); else passed++;
      c = 0;
      while (!acked && c < 20) begin
        tick();
        if (edge_ack) acked = 1'b1;
        else begin
          total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0300) $display("FAIL drain_hold: got req=%b addr=%h want 1 00000300", imem_req_o, imem_addr_o); else passed++;
        end
        total++; if (valid_o !== 1'b0 || inst_o !== 32'd0) $display("FAIL drain_no_data: got v=%b inst=%h want 0 0", valid_o, inst_o); else passed++;
        c++;
      end
      total++; if (!acked) $display("FAIL drain_timeout: got no ack want ack"); else passed++;
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0080) $display("FAIL restart_addr: got req=%b addr=%h want 1 00000080", imem_req_o, imem_addr_o); else passed++;
      push(32'h0000_0080); push(32'h0000_0084);
      c = 0;
      while (exp_q.size() > 0 && c < 60) begin
        tick();
        if (valid_o && !edge_stall) begin
          e = exp_q.pop_front();
          total++; if (pc_o !== e.pc || inst_o !== e.inst) $display("FAIL flush_seq: got pc=%h inst=%h want pc=%h inst=%h", pc_o, inst_o, e.pc, e.inst); else passed++;
        end
        c++;
      end
      total++; if (exp_q.size() != 0) $display("FAIL flush_timeout: got %0d pending want 0", exp_q.size()); else passed++;
    end
  endtask

  task automatic test_flush_priority();
    exp_t e;
    int c;
    wait_n = 0;
    redirect(32'h0000_0700);
    exp_q.delete();
    tick();
    tick();
    stall_i = 1'b1;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h0000_0900;
    flush_pc_i = 32'h0000_0040;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0;
    total++; if (valid_o !== 1'b0 || inst_o !== 32'd0) $display("FAIL prio_invalid: got v=%b inst=%h want 0 0", valid_o, inst_o); else passed++;
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0040) $display("FAIL prio_restart: got req=%b addr=%h want 1 00000040", imem_req_o, imem_addr_o); else passed++;
    push(32'h0000_0040); push(32'h0000_0044);
    c = 0;
    while (exp_q.size() > 0 && c < 30) begin
      tick();
      if (valid_o && !edge_stall) begin
        e = exp_q.pop_front();
        total++; if (pc_o !== e.pc || inst_o !== e.inst) $display("FAIL prio_seq: got pc=%h inst=%h want pc=%h inst=%h", pc_o, inst_o, e.pc, e.inst); else passed++;
      end
      c++;
    end
    total++; if (exp_q.size() != 0) $display("FAIL prio_timeout: got %0d pending want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_wrap();
    exp_t e;
    int c;
    wait_n = 0;
    redirect(32'hFFFF_FFF8);
    exp_q.delete();
    push(32'hFFFF_FFF8); push(32'hFFFF_FFFC); push(32'h0000_0000); push(32'h0000_0004);
    c = 0;
    while (exp_q.size() > 0 && c < 30) begin
      tick();
      if (valid_o && !edge_stall) begin
        e = exp_q.pop_front();
        total++; if (pc_o !== e.pc || inst_o !== e.inst) $display("FAIL wrap_seq: got pc=%h inst=%h want pc=%h inst=%h", pc_o, inst_o, e.pc, e.inst); else passed++;
      end
      c++;
    end
    total++; if (exp_q.size() != 0) $display("FAIL wrap_timeout: got %0d pending want 0", exp_q.size()); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_branch(0);
    test_branch(3);
    test_flush_inflight();
    test_flush_priority();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
